ex_mem_stage: RTL and testbench

- EX/MEM pipeline register with branch/jump resolution. It sits directly downstream of the EX-stage ALU.
- It captures the ALU result and N/Z/C/V flags, the ID_EX control bits and the store data, then resolves conditional branches from the flags.
- It issues a one-cycle PC redirect on a taken branch or jump (static predict-not-taken) and squashes the wrong-path instruction in EX.
- It keeps saturating branch statistics counters.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/branch_cond.sv | 25 ++
 rtl/ex_mem_stage.sv | 130 +++++++++++++
 tb/tb_ex_mem_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 pipeline constants: widths, branch funct3, ALU ops
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Branch resolution relies on decode selecting SUB so the flags describe rs1 - rs2.
    localparam logic [4:0] ALU_SUB = 5'b10000;

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - branch condition from funct3 and N/Z/C/V of rs1 - rs2
module branch_cond (
    input  logic [2:0] funct3,
    input  logic       n,
    input  logic       z,
    input  logic       c,
    input  logic       v,
    output logic       cond
);
    import riscv_pkg::*;

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = z;
            F3_BNE:  cond = ~z;
            F3_BLT:  cond = n ^ v;
            F3_BGE:  cond = ~(n ^ v);
            F3_BLTU: cond = ~c;
            F3_BGEU: cond = c;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with branch/jump resolution and redirect
module ex_mem_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             ID_EX_valid,
    input  logic [XLEN-1:0]  ID_EX_pc,
    input  logic [XLEN-1:0]  ID_EX_imm,
    input  logic [XLEN-1:0]  ID_EX_rs2_data,
    input  logic [RA_W-1:0]  ID_EX_rd,
    input  logic             ID_EX_RegWrite,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_MemWrite,
    input  logic             ID_EX_MemtoReg,
    input  logic             ID_EX_Branch,
    input  logic             ID_EX_Jal,
    input  logic             ID_EX_Jalr,
    input  logic [2:0]       ID_EX_funct3,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             N,
    input  logic             Z,
    input  logic             C,
    input  logic             V,
    output logic             EX_MEM_valid,
    output logic             EX_MEM_RegWrite,
    output logic             EX_MEM_MemRead,
    output logic             EX_MEM_MemWrite,
    output logic             EX_MEM_MemtoReg,
    output logic [XLEN-1:0]  EX_MEM_result,
    output logic [XLEN-1:0]  EX_MEM_store_data,
    output logic [RA_W-1:0]  EX_MEM_rd,
    output logic [2:0]       EX_MEM_funct3,
    output logic             EX_MEM_misalign,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_target,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken
);

    logic            squash_pending;
    logic            eff_valid;
    logic            cond;
    logic            is_jump;
    logic            taken;
    logic            misalign;
    logic            redirect_go;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link_pc;

    branch_cond u_branch_cond (
        .funct3 (ID_EX_funct3),
        .n      (N),
        .z      (Z),
        .c      (C),
        .v      (V),
        .cond   (cond)
    );

    assign eff_valid   = ID_EX_valid & ~squash_pending;
    assign is_jump     = ID_EX_Jal | ID_EX_Jalr;
    assign taken       = eff_valid & (is_jump | (ID_EX_Branch & cond));
    assign target      = ID_EX_Jalr ? {alu_result[XLEN-1:1], 1'b0} : ID_EX_pc + ID_EX_imm;
    assign misalign    = taken & target[1];
    assign redirect_go = taken & ~target[1];
    assign link_pc     = ID_EX_pc + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            EX_MEM_valid      <= 1'b0;
            EX_MEM_RegWrite   <= 1'b0;
            EX_MEM_MemRead    <= 1'b0;
            EX_MEM_MemWrite   <= 1'b0;
            EX_MEM_MemtoReg   <= 1'b0;
            EX_MEM_result     <= '0;
            EX_MEM_store_data <= '0;
            EX_MEM_rd         <= '0;
            EX_MEM_funct3     <= '0;
            EX_MEM_misalign   <= 1'b0;
            redirect          <= 1'b0;
            redirect_target   <= '0;
            squash_pending    <= 1'b0;
            cnt_branch        <= '0;
            cnt_taken         <= '0;
        end else begin
            // The pulse always drops after one cycle, even when MEM stalls.
            redirect <= 1'b0;
            if (!stall) begin
                if (eff_valid) begin
                    EX_MEM_valid      <= 1'b1;
                    EX_MEM_RegWrite   <= ID_EX_RegWrite & ~misalign;
                    EX_MEM_MemRead    <= ID_EX_MemRead  & ~misalign;
                    EX_MEM_MemWrite   <= ID_EX_MemWrite & ~misalign;
                    EX_MEM_MemtoReg   <= ID_EX_MemtoReg;
                    EX_MEM_result     <= is_jump ? link_pc : alu_result;
                    EX_MEM_store_data <= ID_EX_rs2_data;
                    EX_MEM_rd         <= ID_EX_rd;
                    EX_MEM_funct3     <= ID_EX_funct3;
                    EX_MEM_misalign   <= misalign;
                end else begin
                    EX_MEM_valid      <= 1'b0;
                    EX_MEM_RegWrite   <= 1'b0;
                    EX_MEM_MemRead    <= 1'b0;
                    EX_MEM_MemWrite   <= 1'b0;
                    EX_MEM_MemtoReg   <= 1'b0;
                    EX_MEM_result     <= '0;
                    EX_MEM_store_data <= '0;
                    EX_MEM_rd         <= '0;
                    EX_MEM_funct3     <= '0;
                    EX_MEM_misalign   <= 1'b0;
                end
                redirect       <= redirect_go;
                squash_pending <= redirect_go;
                if (redirect_go) begin
                    redirect_target <= target;
                end
                if (eff_valid && ID_EX_Branch && (cnt_branch != '1)) begin
                    cnt_branch <= cnt_branch + CNT_W'(1);
                end
                if (eff_valid && ID_EX_Branch && cond && (cnt_taken != '1)) begin
                    cnt_taken <= cnt_taken + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed vector bench for ex_mem_stage
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc, id_imm, id_rs2;
    logic [4:0]  id_rd;
    logic        id_regw, id_memr, id_memw, id_m2r, id_br, id_jal, id_jalr;
    logic [2:0]  id_f3;
    logic [31:0] alu;
    logic        f_n, f_z, f_c, f_v;

    logic        o_valid, o_regw, o_memr, o_memw, o_m2r, o_mis, o_red;
    logic [31:0] o_res, o_sd, o_tgt, o_cb, o_ct;
    logic [4:0]  o_rd;
    logic [2:0]  o_f3;

    logic        s_valid, s_regw, s_memr, s_memw, s_m2r, s_mis, s_red;
    logic [31:0] s_res, s_sd, s_tgt;
    logic [4:0]  s_rd;
    logic [2:0]  s_f3;
    logic [1:0]  s_cb, s_ct;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.XLEN(32), .RA_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .ID_EX_valid(id_valid), .ID_EX_pc(id_pc), .ID_EX_imm(id_imm),
        .ID_EX_rs2_data(id_rs2), .ID_EX_rd(id_rd),
        .ID_EX_RegWrite(id_regw), .ID_EX_MemRead(id_memr), .ID_EX_MemWrite(id_memw),
        .ID_EX_MemtoReg(id_m2r), .ID_EX_Branch(id_br), .ID_EX_Jal(id_jal),
        .ID_EX_Jalr(id_jalr), .ID_EX_funct3(id_f3), .alu_result(alu),
        .N(f_n), .Z(f_z), .C(f_c), .V(f_v),
        .EX_MEM_valid(o_valid), .EX_MEM_RegWrite(o_regw), .EX_MEM_MemRead(o_memr),
        .EX_MEM_MemWrite(o_memw), .EX_MEM_MemtoReg(o_m2r), .EX_MEM_result(o_res),
        .EX_MEM_store_data(o_sd), .EX_MEM_rd(o_rd), .EX_MEM_funct3(o_f3),
        .EX_MEM_misalign(o_mis), .redirect(o_red), .redirect_target(o_tgt),
        .cnt_branch(o_cb), .cnt_taken(o_ct)
    );

    // Narrow counters so saturation is reachable in a few branches.
    ex_mem_stage #(.XLEN(32), .RA_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .ID_EX_valid(id_valid), .ID_EX_pc(id_pc), .ID_EX_imm(id_imm),
        .ID_EX_rs2_data(id_rs2), .ID_EX_rd(id_rd),
        .ID_EX_RegWrite(id_regw), .ID_EX_MemRead(id_memr), .ID_EX_MemWrite(id_memw),
        .ID_EX_MemtoReg(id_m2r), .ID_EX_Branch(id_br), .ID_EX_Jal(id_jal),
        .ID_EX_Jalr(id_jalr), .ID_EX_funct3(id_f3), .alu_result(alu),
        .N(f_n), .Z(f_z), .C(f_c), .V(f_v),
        .EX_MEM_valid(s_valid), .EX_MEM_RegWrite(s_regw), .EX_MEM_MemRead(s_memr),
        .EX_MEM_MemWrite(s_memw), .EX_MEM_MemtoReg(s_m2r), .EX_MEM_result(s_res),
        .EX_MEM_store_data(s_sd), .EX_MEM_rd(s_rd), .EX_MEM_funct3(s_f3),
        .EX_MEM_misalign(s_mis), .redirect(s_red), .redirect_target(s_tgt),
        .cnt_branch(s_cb), .cnt_taken(s_ct)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        regw;
        logic        memw;
        logic        br;
        logic        jal;
        logic        jalr;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [3:0]  nzcv;
        logic        e_valid;
        logic        e_regw;
        logic        e_memw;
        logic        e_mis;
        logic        e_red;
        logic [31:0] e_res;
        logic [31:0] e_tgt;
        int          e_cb;
        int          e_ct;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_pc = 0; id_imm = 0; id_rs2 = 0; id_rd = 0;
        id_regw = 0; id_memr = 0; id_memw = 0; id_m2r = 0;
        id_br = 0; id_jal = 0; id_jalr = 0; id_f3 = 0; alu = 0;
        f_n = 0; f_z = 0; f_c = 0; f_v = 0;
    endtask

    task automatic drive(input vec_t t);
        id_valid = t.valid; id_pc = t.pc; id_imm = t.imm; id_rd = t.rd;
        id_rs2 = t.pc ^ 32'hA5A5_0000;
        id_regw = t.regw; id_memr = 0; id_memw = t.memw; id_m2r = 0;
        id_br = t.br; id_jal = t.jal; id_jalr = t.jalr; id_f3 = t.f3; alu = t.alu;
        {f_n, f_z, f_c, f_v} = t.nzcv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           valid pc          imm            rd  rw mw br jl jr f3      alu          nzcv     ev rw mw mis red res          tgt          cb ct
        vecs[0]  = '{0, 32'h0,   32'h0,         5'd0, 0, 0, 0, 0, 0, 3'b000, 32'h0,    4'b0000, 0, 0, 0, 0, 0, 32'h0,    32'h0,   0, 0};
        vecs[1]  = '{1, 32'h100, 32'h20,        5'd0, 0, 0, 1, 0, 0, 3'b000, 32'h0,    4'b0100, 1, 0, 0, 0, 1, 32'h0,    32'h120, 1, 1};
        vecs[2]  = '{1, 32'h104, 32'h0,         5'd3, 1, 0, 0, 0, 0, 3'b000, 32'h55,   4'b0000, 0, 0, 0, 0, 0, 32'h0,    32'h0,   1, 1};
        vecs[3]  = '{1, 32'h120, 32'h0,         5'd3, 1, 0, 0, 0, 0, 3'b000, 32'h55,   4'b0000, 1, 1, 0, 0, 0, 32'h55,   32'h0,   1, 1};
        vecs[4]  = '{1, 32'h124, 32'h40,        5'd0, 0, 0, 1, 0, 0, 3'b100, 32'h0,    4'b1001, 1, 0, 0, 0, 0, 32'h0,    32'h0,   2, 1};
        vecs[5]  = '{1, 32'h300, 32'hFFFF_FFF8, 5'd0, 0, 0, 1, 0, 0, 3'b110, 32'h9,    4'b1000, 1, 0, 0, 0, 1, 32'h9,    32'h2F8, 3, 2};
        vecs[6]  = '{1, 32'h304, 32'h20,        5'd0, 0, 0, 1, 0, 0, 3'b000, 32'h0,    4'b0100, 0, 0, 0, 0, 0, 32'h0,    32'h0,   3, 2};
        vecs[7]  = '{1, 32'h200, 32'h0,         5'd1, 1, 0, 0, 0, 1, 3'b000, 32'h305,  4'b0000, 1, 1, 0, 0, 1, 32'h204,  32'h304, 3, 2};
        vecs[8]  = '{0, 32'h0,   32'h0,         5'd0, 0, 0, 0, 0, 0, 3'b000, 32'h0,    4'b0000, 0, 0, 0, 0, 0, 32'h0,    32'h0,   3, 2};
        vecs[9]  = '{1, 32'h600, 32'h8,         5'd0, 0, 0, 1, 0, 0, 3'b101, 32'h1,    4'b1000, 1, 0, 0, 0, 0, 32'h1,    32'h0,   4, 2};
        vecs[10] = '{1, 32'h400, 32'h10,        5'd0, 0, 0, 1, 0, 0, 3'b111, 32'h2,    4'b0010, 1, 0, 0, 0, 1, 32'h2,    32'h410, 5, 3};
        vecs[11] = '{0, 32'h0,   32'h0,         5'd0, 0, 0, 0, 0, 0, 3'b000, 32'h0,    4'b0000, 0, 0, 0, 0, 0, 32'h0,    32'h0,   5, 3};
        vecs[12] = '{1, 32'h700, 32'h8,         5'd0, 0, 0, 1, 0, 0, 3'b010, 32'h3,    4'b0100, 1, 0, 0, 0, 0, 32'h3,    32'h0,   6, 3};
        vecs[13] = '{1, 32'h10,  32'h6,         5'd7, 1, 1, 1, 0, 0, 3'b001, 32'h4,    4'b0000, 1, 0, 0, 1, 0, 32'h4,    32'h0,   7, 4};
        vecs[14] = '{1, 32'h14,  32'h0,         5'd0, 0, 1, 0, 0, 0, 3'b010, 32'h1000, 4'b0000, 1, 0, 1, 0, 0, 32'h1000, 32'h0,   7, 4};

        rst_n = 0;
        stall = 0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        #1;
        check("reset_valid", {31'b0, o_valid}, 0);
        check("reset_redirect", {31'b0, o_red}, 0);
        check("reset_target", o_tgt, 0);
        check("reset_result", o_res, 0);
        check("reset_cnt_branch", o_cb, 0);
        check("reset_cnt_taken", o_ct, 0);
        #3;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i]);
            step();
            check($sformatf("v%0d_valid", i), {31'b0, o_valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("v%0d_regw", i), {31'b0, o_regw}, {31'b0, vecs[i].e_regw});
            check($sformatf("v%0d_memw", i), {31'b0, o_memw}, {31'b0, vecs[i].e_memw});
            check($sformatf("v%0d_misalign", i), {31'b0, o_mis}, {31'b0, vecs[i].e_mis});
            check($sformatf("v%0d_redirect", i), {31'b0, o_red}, {31'b0, vecs[i].e_red});
            check($sformatf("v%0d_cnt_branch", i), o_cb, vecs[i].e_cb);
            check($sformatf("v%0d_cnt_taken", i), o_ct, vecs[i].e_ct);
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d_result", i), o_res, vecs[i].e_res);
                check($sformatf("v%0d_rd", i), {27'b0, o_rd}, {27'b0, vecs[i].rd});
                check($sformatf("v%0d_store", i), o_sd, vecs[i].pc ^ 32'hA5A5_0000);
            end
            if (vecs[i].e_red) begin
                check($sformatf("v%0d_target", i), o_tgt, vecs[i].e_tgt);
            end
        end

        // Taken BNE, then a three-cycle MEM stall with a younger instruction waiting in EX.
        idle_inputs();
        id_valid = 1; id_pc = 32'h500; id_imm = 32'h40; id_br = 1; id_f3 = 3'b001; alu = 32'h11;
        step();
        check("bne_redirect", {31'b0, o_red}, 1);
        check("bne_target", o_tgt, 32'h540);
        check("bne_cnt_taken", o_ct, 5);
        idle_inputs();
        id_valid = 1; id_pc = 32'h504; alu = 32'h77; id_regw = 1; id_rd = 5'd9;
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall%0d_redirect", k), {31'b0, o_red}, 0);
            check($sformatf("stall%0d_valid", k), {31'b0, o_valid}, 1);
            check($sformatf("stall%0d_result", k), o_res, 32'h11);
            check($sformatf("stall%0d_target", k), o_tgt, 32'h540);
            check($sformatf("stall%0d_cnt_branch", k), o_cb, 8);
        end
        stall = 0;
        step();
        check("post_stall_bubble", {31'b0, o_valid}, 0);
        check("post_stall_redirect", {31'b0, o_red}, 0);
        step();
        check("post_stall_valid", {31'b0, o_valid}, 1);
        check("post_stall_result", o_res, 32'h77);
        check("post_stall_regw", {31'b0, o_regw}, 1);

        // JAL to a misaligned target: trap marker, no redirect, side effects suppressed.
        idle_inputs();
        id_valid = 1; id_pc = 32'h100; id_imm = 32'h2; id_jal = 1; id_regw = 1; id_memr = 1;
        step();
        check("jal_mis_misalign", {31'b0, o_mis}, 1);
        check("jal_mis_valid", {31'b0, o_valid}, 1);
        check("jal_mis_regw", {31'b0, o_regw}, 0);
        check("jal_mis_memr", {31'b0, o_memr}, 0);
        check("jal_mis_redirect", {31'b0, o_red}, 0);
        check("jal_mis_result", o_res, 32'h104);
        check("jal_mis_cnt_branch", o_cb, 8);

        // Asynchronous reset in the middle of a stall.
        stall = 1;
        idle_inputs();
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        check("async_rst_valid", {31'b0, o_valid}, 0);
        check("async_rst_misalign", {31'b0, o_mis}, 0);
        check("async_rst_result", o_res, 0);
        check("async_rst_target", o_tgt, 0);
        check("async_rst_cnt_branch", o_cb, 0);
        check("async_rst_cnt_taken", o_ct, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        stall = 0;

        // Eight back-to-back taken BEQs: every other one is squashed.
        id_valid = 1; id_pc = 32'h800; id_imm = 32'h20; id_br = 1; id_f3 = 3'b000; f_z = 1;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("b2b%0d_redirect", k), {31'b0, o_red}, ((k % 2) == 0) ? 32'd1 : 32'd0);
        end
        check("b2b_cnt_branch", o_cb, 4);
        check("b2b_cnt_taken", o_ct, 4);
        check("sat_cnt_branch", {30'b0, s_cb}, 3);
        check("sat_cnt_taken", {30'b0, s_ct}, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
